// File: rtl/m_uart_txarb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The FSM encoding is exported so benches can observe the state.
package m_uart_txarb_pkg;

    typedef enum logic [1:0] {
        TXARB_IDLE = 2'd0,
        TXARB_CON  = 2'd1,
        TXARB_DUMP = 2'd2
    } txarb_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Index of the LF byte, the last byte of a dump message.
    localparam logic [3:0] DUMP_LAST_IDX = 4'd9;

endpackage

// File: rtl/m_uart_txarb_if.sv
// Bus between the console/debug producers plus the serializer and the arbiter.
// master = producer/serializer side, slave = the arbiter.
interface m_uart_txarb_if;
    logic [7:0]  con_data;
    logic        con_we;
    logic        con_full;
    logic        dbg_req;
    logic [31:0] dbg_word;
    logic        dbg_busy;
    // tx handshake: a byte moves when tx_valid & tx_ready at posedge; once tx_valid
    // is high, tx_data holds and tx_valid stays high until that transfer (reset aside).
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ovf;
    logic        ovf_clr;

    modport master (
        output con_data, con_we, dbg_req, dbg_word, tx_ready, ovf_clr,
        input  con_full, dbg_busy, tx_data, tx_valid, ovf
    );

    modport slave (
        input  con_data, con_we, dbg_req, dbg_word, tx_ready, ovf_clr,
        output con_full, dbg_busy, tx_data, tx_valid, ovf
    );
endinterface

// File: rtl/m_uart_txarb_fifo.sv
// Synchronous console FIFO with registered count; exposes head and the entry after it
// so the arbiter can present consecutive bytes without a bubble.
module m_uart_txarb_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [W-1:0]             next_head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rptr_inc;

    assign rptr_inc  = rptr + AW'(1);
    assign head      = mem[rptr];
    assign next_head = mem[rptr_inc];
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr_inc;
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/m_uart_txarb.sv
// Shares one UART transmitter between the buffered console stream and an atomic
// 10-byte hex dump (8 hex chars + CR + LF), alternating fairly under contention.
module m_uart_txarb
    import m_uart_txarb_pkg::*;
#(
    parameter int CON_DEPTH = 16,
    parameter int MAX_BURST = 8,
    parameter bit UPPER_HEX = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    m_uart_txarb_if.slave bus,
    output txarb_state_e  state_dbg
);
    localparam int AW = $clog2(CON_DEPTH);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    txarb_state_e  state, state_nx;
    logic [7:0]    tx_data, tx_data_nx;
    logic          tx_valid, tx_valid_nx;
    logic [BW-1:0] burst, burst_nx;
    logic          last_con, last_con_nx;
    logic [3:0]    idx, idx_nx;
    logic [31:0]   dump_word;
    logic          busy;
    logic          dump_done;
    logic          dump_pending;
    logic          ovf;
    logic          transfer;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head, fifo_next;
    logic [AW:0]   fifo_count;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    // Byte i of the dump message: nibbles MSB first, then CR, then LF.
    function automatic logic [7:0] dump_byte(input logic [31:0] w, input logic [3:0] i);
        case (i)
            4'd8:    return ASCII_CR;
            4'd9:    return ASCII_LF;
            default: return hex_char(w[{~i[2:0], 2'b00} +: 4]);
        endcase
    endfunction

    assign transfer     = tx_valid & bus.tx_ready;
    assign fifo_push    = bus.con_we & ~fifo_full;
    assign dump_pending = busy & (state != TXARB_DUMP);

    m_uart_txarb_fifo #(.DEPTH(CON_DEPTH), .W(8)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .wdata     (bus.con_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .next_head (fifo_next),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TXARB_IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            burst    <= '0;
            last_con <= 1'b0;
            idx      <= 4'd0;
        end else begin
            state    <= state_nx;
            tx_data  <= tx_data_nx;
            tx_valid <= tx_valid_nx;
            burst    <= burst_nx;
            last_con <= last_con_nx;
            idx      <= idx_nx;
        end
    end

    // The displayed console byte stays in the FIFO until it is transferred, so the
    // FIFO count covers every byte not yet handed to the serializer.
    always_comb begin
        state_nx    = state;
        tx_data_nx  = tx_data;
        tx_valid_nx = tx_valid;
        burst_nx    = burst;
        last_con_nx = last_con;
        idx_nx      = idx;
        fifo_pop    = 1'b0;
        dump_done   = 1'b0;
        case (state)
            TXARB_IDLE: begin
                if (!fifo_empty && (!dump_pending || !last_con)) begin
                    state_nx    = TXARB_CON;
                    tx_data_nx  = fifo_head;
                    tx_valid_nx = 1'b1;
                    burst_nx    = BW'(1);
                end else if (dump_pending) begin
                    state_nx    = TXARB_DUMP;
                    idx_nx      = 4'd0;
                    tx_data_nx  = dump_byte(dump_word, 4'd0);
                    tx_valid_nx = 1'b1;
                end
            end
            TXARB_CON: begin
                if (transfer) begin
                    fifo_pop = 1'b1;
                    if (fifo_count > (AW+1)'(1) && !(burst == BURST_MAX && dump_pending)) begin
                        tx_data_nx = fifo_next;
                        if (burst < BURST_MAX) burst_nx = burst + BW'(1);
                    end else begin
                        state_nx    = TXARB_IDLE;
                        tx_valid_nx = 1'b0;
                        last_con_nx = 1'b1;
                        burst_nx    = '0;
                    end
                end
            end
            TXARB_DUMP: begin
                if (transfer) begin
                    if (idx == DUMP_LAST_IDX) begin
                        state_nx    = TXARB_IDLE;
                        tx_valid_nx = 1'b0;
                        last_con_nx = 1'b0;
                        dump_done   = 1'b1;
                    end else begin
                        idx_nx     = idx + 4'd1;
                        tx_data_nx = dump_byte(dump_word, idx + 4'd1);
                    end
                end
            end
            default: begin
                state_nx    = TXARB_IDLE;
                tx_valid_nx = 1'b0;
            end
        endcase
    end

    // Requests arriving while busy (including the LF cycle) are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            dump_word <= 32'h0;
        end else if (dump_done) begin
            busy <= 1'b0;
        end else if (bus.dbg_req && !busy) begin
            busy      <= 1'b1;
            dump_word <= bus.dbg_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           ovf <= 1'b0;
        else if (bus.con_we && fifo_full)  ovf <= 1'b1;
        else if (bus.ovf_clr)              ovf <= 1'b0;
    end

    assign bus.con_full = fifo_full;
    assign bus.dbg_busy = busy;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign bus.ovf      = ovf;
    assign state_dbg    = state;
endmodule
